hazard_sweep_checker: RTL and testbench

//  Self-running hazard test engine for small combinational blocks (FD-style hazard circuits), IN_W inputs, OUT_W outputs.

---
 rtl/hazard_sweep_checker.sv | 156 +++++++++++++++
 tb/tb_hazard_sweep_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sweep_checker.sv
// Self-running hazard sweep: drives every ordered from->to input transition into a
// combinational DUT, oversamples its outputs and flags static and dynamic hazards.
module hazard_sweep_checker #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 1,
    parameter int HOLD  = 7,
    parameter int CNT_W = 2 * IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             hazard_pulse,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic             first_valid,
    output logic [IN_W-1:0]  first_from,
    output logic [IN_W-1:0]  first_to,
    output logic [1:0]       first_type
);

    localparam logic [IN_W-1:0]  MAX_V   = '1;
    localparam logic [IN_W-1:0]  ONE_V   = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LAST_K  = 8'(HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_FROM, S_TO, S_DONE} state_t;

    state_t                  state, state_n;
    logic [7:0]              cnt;
    logic [IN_W-1:0]         i_q, j_q;
    logic [OUT_W-1:0]        ref_q, prev_q, stat, dyn;
    logic [OUT_W-1:0][1:0]   tog_q, tog_n;
    logic                    phase_end, last_pair, verdict;

    assign phase_end = (cnt == LAST_K);
    assign last_pair = (i_q == MAX_V) && (j_q == MAX_V);
    assign busy      = (state == S_FROM) || (state == S_TO);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = S_FROM;
            S_FROM: if (phase_end) state_n = S_TO;
            S_TO:   if (phase_end) state_n = last_pair ? S_DONE : S_FROM;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Toggle count includes the sample taken this cycle, so the verdict at the last
    // TO edge sees all HOLD samples against the FROM reference.
    always_comb begin
        tog_n = tog_q;
        stat  = '0;
        dyn   = '0;
        for (int b = 0; b < OUT_W; b++) begin
            if (tog_q[b] != 2'd3)
                tog_n[b] = tog_q[b] + {1'b0, dut_out[b] ^ prev_q[b]};
            stat[b] = (ref_q[b] == dut_out[b]) && (tog_n[b] != 2'd0);
            dyn[b]  = (ref_q[b] != dut_out[b]) && (tog_n[b] > 2'd1);
        end
    end

    assign verdict = (state == S_TO) && phase_end && ((|stat) || (|dyn));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            i_q          <= ONE_V;
            j_q          <= '0;
            dut_in       <= '0;
            ref_q        <= '0;
            prev_q       <= '0;
            tog_q        <= '0;
            hazard_pulse <= 1'b0;
            hazard_cnt   <= '0;
            first_valid  <= 1'b0;
            first_from   <= '0;
            first_to     <= '0;
            first_type   <= '0;
        end else begin
            hazard_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        i_q         <= ONE_V;
                        j_q         <= '0;
                        dut_in      <= '0;
                        hazard_cnt  <= '0;
                        first_valid <= 1'b0;
                        first_from  <= '0;
                        first_to    <= '0;
                        first_type  <= '0;
                    end
                end
                S_FROM: begin
                    if (phase_end) begin
                        cnt    <= '0;
                        dut_in <= j_q + i_q;
                        ref_q  <= dut_out;
                        prev_q <= dut_out;
                        tog_q  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_TO: begin
                    tog_q  <= tog_n;
                    prev_q <= dut_out;
                    if (phase_end) begin
                        cnt <= '0;
                        if (verdict) begin
                            hazard_pulse <= 1'b1;
                            if (hazard_cnt != '1) hazard_cnt <= hazard_cnt + ONE_CNT;
                            if (!first_valid) begin
                                first_valid <= 1'b1;
                                first_from  <= j_q;
                                first_to    <= j_q + i_q;
                                first_type  <= {|dyn, |stat};
                            end
                        end
                        // Last pair leaves dut_in on its TO vector through DONE.
                        if (!last_pair) begin
                            if (j_q == MAX_V) begin
                                j_q    <= '0;
                                i_q    <= i_q + ONE_V;
                                dut_in <= '0;
                            end else begin
                                j_q    <= j_q + ONE_V;
                                dut_in <= j_q + ONE_V;
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    i_q <= ONE_V;
                    j_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sweep_checker.sv
// Bench for hazard_sweep_checker: directed dut_out scenarios, a done-triggered
// monitor popping per-run expectations, and per-cycle checks of the swept vector.
module tb_hazard_sweep_checker;

    localparam int IN_W  = 3;
    localparam int OUT_W = 1;
    localparam int HOLD  = 4;
    localparam int CNT_W = 2 * IN_W;
    localparam int RUN   = 7 * 8 * 2 * HOLD;

    logic             clk, rst, start;
    logic [OUT_W-1:0] dut_out;
    logic [IN_W-1:0]  dut_in;
    logic             busy, done, hazard_pulse, first_valid;
    logic [CNT_W-1:0] hazard_cnt;
    logic [IN_W-1:0]  first_from, first_to;
    logic [1:0]       first_type;

    int total = 0;
    int bad   = 0;
    int scen  = 0;
    logic drv = 1'b0;

    // expected entry: busy cycles, pulses, hazard_cnt, first_valid, first_from, first_to, first_type
    logic [30:0] exp_q[$];

    hazard_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .done(done), .hazard_pulse(hazard_pulse), .hazard_cnt(hazard_cnt),
        .first_valid(first_valid), .first_from(first_from), .first_to(first_to),
        .first_type(first_type)
    );

    // Scenario 1 is a glitch-free block: out = c = dut_in[2].
    assign dut_out[0] = (scen == 1) ? dut_in[2] : drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [30:0] pack(input int bn, input int pn, input int hc,
                                         input int fv, input int ff, input int ft, input int ty);
        return {12'(bn), 4'(pn), 6'(hc), 1'(fv), 3'(ff), 3'(ft), 2'(ty)};
    endfunction

    // Stimulus model: drives dut_out for busy cycle bcount and checks the swept vector.
    int bcount = 0;
    int p, ph, k, ii, jj;
    always @(negedge clk) begin
        if (busy) begin
            p  = bcount / (2 * HOLD);
            ph = (bcount % (2 * HOLD)) / HOLD;
            k  = bcount % HOLD;
            ii = p / 8 + 1;
            jj = p % 8;
            check("pair_vec", int'(dut_in), (ph == 0) ? jj : ((jj + ii) % 8));
            drv = 1'b0;
            if (scen == 2 && p == 53 && ph == 1 && k == 1) drv = 1'b1;
            if (scen == 3 && p == 0 && ph == 1) drv = (k != 1);
            bcount++;
        end else begin
            bcount = 0;
            drv    = 1'b0;
        end
    end

    // Monitor: accumulates per-run activity and compares at each done pulse.
    int busy_n = 0, pulse_n = 0, done_n = 0;
    logic [30:0] e;
    always @(negedge clk) begin
        if (rst) begin
            busy_n  = 0;
            pulse_n = 0;
        end else begin
            if (busy) busy_n++;
            if (hazard_pulse) pulse_n++;
            if (done) begin
                done_n++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("busy_cycles", busy_n, int'(e[30:19]));
                    check("pulse_count", pulse_n, int'(e[18:15]));
                    check("hazard_cnt", int'(hazard_cnt), int'(e[14:9]));
                    check("first_valid", int'(first_valid), int'(e[8]));
                    check("first_from", int'(first_from), int'(e[7:5]));
                    check("first_to", int'(first_to), int'(e[4:2]));
                    check("first_type", int'(first_type), int'(e[1:0]));
                end
                busy_n  = 0;
                pulse_n = 0;
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < RUN + 50) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done), 1);
    endtask

    task automatic run(input int s, input logic [30:0] ex);
        scen = s;
        exp_q.push_back(ex);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dut_in", int'(dut_in), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pulse", int'(hazard_pulse), 0);
        check("rst_hazard_cnt", int'(hazard_cnt), 0);
        check("rst_first_valid", int'(first_valid), 0);

        run(0, pack(RUN, 0, 0, 0, 0, 0, 0));
        run(1, pack(RUN, 0, 0, 0, 0, 0, 0));
        run(2, pack(RUN, 1, 1, 1, 5, 4, 1));
        run(3, pack(RUN, 1, 1, 1, 0, 1, 2));

        // Abort mid-sweep with a hazard already counted.
        scen = 3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_rst_hazard_cnt", int'(hazard_cnt), 1);
        check("pre_rst_busy", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("abort_dut_in", int'(dut_in), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_hazard_cnt", int'(hazard_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(0, pack(RUN, 0, 0, 0, 0, 0, 0));

        // start held across a whole run: exactly one sweep.
        scen = 2;
        exp_q.push_back(pack(RUN, 1, 1, 1, 5, 4, 1));
        @(negedge clk) start = 1'b1;
        wait_done();
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("held_no_rerun_busy", int'(busy), 0);
        check("idle_hold_hazard_cnt", int'(hazard_cnt), 1);
        check("idle_hold_first_valid", int'(first_valid), 1);

        // A fresh start clears the previous results at acceptance.
        scen = 0;
        exp_q.push_back(pack(RUN, 0, 0, 0, 0, 0, 0));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("restart_clear_cnt", int'(hazard_cnt), 0);
        check("restart_clear_valid", int'(first_valid), 0);
        wait_done();

        repeat (5) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("done_pulses", done_n, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
